// File: rtl/audio_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : audio_frame_ctrl
//  Purpose  : Turns codec LR-clock sample events into ping-pong frame RAM
//             writes and offers each completed bank to the FFT core.
//  Options  : AUDIO_FRAME_MIX_EN - write (L+R)/2 instead of the ch_sel channel
//  Revision : 1.0 - initial release
// ============================================================================
module audio_frame_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              adclrck,
    input  logic [DATA_W-1:0] sample_l,
    input  logic [DATA_W-1:0] sample_r,
    input  logic              ch_sel,
    input  logic              frame_ack,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_valid,
    output logic              frame_bank,
    output logic              busy,
    output logic [7:0]        overrun_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FILL    = 2'd1,
        S_OVERRUN = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] c_addr_last = '1;

    state_t            r_state, w_state_n;
    logic [2:0]        r_sync;
    logic              r_evt;
    logic [1:0]        r_bank_full, w_bank_full_n, w_full_acked;
    logic              r_fb, w_fb_n;
    logic              r_old, w_old_n;
    logic [ADDR_W-1:0] r_addr, w_addr_n;
    logic [7:0]        r_ovr, w_ovr_n;
    logic              r_wr_en, w_wr_en_n;
    logic              r_wr_bank, w_wr_bank_n;
    logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_n;
    logic [DATA_W-1:0] r_wr_data, w_wr_data_n;
    logic [DATA_W-1:0] w_sample;
    logic              w_ack;

`ifdef AUDIO_FRAME_MIX_EN
    logic [DATA_W:0] w_sum;
    logic            w_unused_bits;
    assign w_sum         = {sample_l[DATA_W-1], sample_l} + {sample_r[DATA_W-1], sample_r};
    // Dropping the LSB of the widened sum is an arithmetic shift that floors.
    assign w_sample      = w_sum[DATA_W:1];
    assign w_unused_bits = ^{ch_sel, w_sum[0]};
`else
    assign w_sample = ch_sel ? sample_r : sample_l;
`endif

    // Two sync flops, one edge-detect flop, then a registered event pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= 3'b000;
            r_evt  <= 1'b0;
        end else begin
            r_sync <= {r_sync[1:0], adclrck};
            r_evt  <= r_sync[1] & ~r_sync[2];
        end
    end

    always_comb begin
        w_ack        = frame_ack & (|r_bank_full);
        // An ack is applied before any completion in the same cycle.
        w_full_acked = r_bank_full;
        if (w_ack) begin
            w_full_acked[r_old] = 1'b0;
        end
        w_state_n     = r_state;
        w_bank_full_n = w_full_acked;
        w_fb_n        = r_fb;
        w_addr_n      = r_addr;
        w_old_n       = w_ack ? ~r_old : r_old;
        w_ovr_n       = r_ovr;
        w_wr_en_n     = 1'b0;
        w_wr_bank_n   = r_wr_bank;
        w_wr_addr_n   = r_wr_addr;
        w_wr_data_n   = r_wr_data;

        if (!run) begin
            w_state_n = S_IDLE;
            w_addr_n  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_addr_n = '0;
                    if (&w_full_acked) begin
                        w_state_n = S_OVERRUN;
                    end else begin
                        w_state_n = S_FILL;
                        w_fb_n    = w_full_acked[0];
                    end
                end
                S_FILL: begin
                    if (r_evt) begin
                        w_wr_en_n   = 1'b1;
                        w_wr_bank_n = r_fb;
                        w_wr_addr_n = r_addr;
                        w_wr_data_n = w_sample;
                        if (r_addr == c_addr_last) begin
                            w_bank_full_n[r_fb] = 1'b1;
                            w_addr_n            = '0;
                            if (w_full_acked[~r_fb]) begin
                                w_state_n = S_OVERRUN;
                            end else begin
                                w_fb_n  = ~r_fb;
                                w_old_n = r_fb;
                            end
                        end else begin
                            w_addr_n = r_addr + ADDR_W'(1);
                        end
                    end
                end
                S_OVERRUN: begin
                    if (r_evt && (r_ovr != 8'hFF)) begin
                        w_ovr_n = r_ovr + 8'd1;
                    end
                    if (w_ack) begin
                        w_state_n = S_FILL;
                        w_fb_n    = r_old;
                        w_addr_n  = '0;
                    end
                end
                default: w_state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bank_full <= 2'b00;
            r_fb        <= 1'b0;
            r_old       <= 1'b0;
            r_addr      <= '0;
            r_ovr       <= 8'd0;
            r_wr_en     <= 1'b0;
            r_wr_bank   <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_state     <= w_state_n;
            r_bank_full <= w_bank_full_n;
            r_fb        <= w_fb_n;
            r_old       <= w_old_n;
            r_addr      <= w_addr_n;
            r_ovr       <= w_ovr_n;
            r_wr_en     <= w_wr_en_n;
            r_wr_bank   <= w_wr_bank_n;
            r_wr_addr   <= w_wr_addr_n;
            r_wr_data   <= w_wr_data_n;
        end
    end

    assign wr_en       = r_wr_en;
    assign wr_bank     = r_wr_bank;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign frame_valid = |r_bank_full;
    assign frame_bank  = r_old;
    assign busy        = (r_state != S_IDLE);
    assign overrun_cnt = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_audio_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_audio_frame_ctrl
//  Purpose  : Randomized bench for audio_frame_ctrl against a frame-level
//             queue model of bank ownership, addressing and drop counting.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_audio_frame_ctrl;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset, run, adclrck, ch_sel, frame_ack;
    logic [DATA_W-1:0] sample_l, sample_r;
    logic              wr_en, wr_bank, frame_valid, frame_bank, busy;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [7:0]        overrun_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Model: queue of completed banks in completion order, plus fill cursor.
    int q[$];
    int m_mode;   // 0 idle, 1 filling, 2 dropping
    int m_fb, m_addr, m_cnt;

    audio_frame_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .run(run), .adclrck(adclrck),
        .sample_l(sample_l), .sample_r(sample_r), .ch_sel(ch_sel),
        .frame_ack(frame_ack), .wr_en(wr_en), .wr_bank(wr_bank),
        .wr_addr(wr_addr), .wr_data(wr_data), .frame_valid(frame_valid),
        .frame_bank(frame_bank), .busy(busy), .overrun_cnt(overrun_cnt)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_sample(input logic [DATA_W-1:0] l,
                                                     input logic [DATA_W-1:0] r,
                                                     input logic sel);
`ifdef AUDIO_FRAME_MIX_EN
        int s;
        s = $signed(l) + $signed(r);
        return DATA_W'(s >>> 1);
`else
        return sel ? r : l;
`endif
    endfunction

    task automatic model_ack();
        int b;
        if (q.size() > 0) begin
            b = q.pop_front();
            if (m_mode == 2) begin
                m_mode = 1;
                m_fb   = b;
                m_addr = 0;
            end
        end
    endtask

    task automatic model_run_start();
        m_addr = 0;
        if (q.size() == 2) m_mode = 2;
        else begin
            m_mode = 1;
            m_fb   = (q.size() == 1 && q[0] == 0) ? 1 : 0;
        end
    endtask

    task automatic check_status(input string where);
        chk({where, ".valid"}, frame_valid, (q.size() > 0));
        if (q.size() > 0) chk({where, ".bank"}, frame_bank, q[0]);
        chk({where, ".busy"}, busy, (m_mode != 0));
        chk({where, ".ovr"}, overrun_cnt, m_cnt);
    endtask

    task automatic send_event(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                              input logic sel, input bit ack_same);
        int  pre;
        bit  w;
        int  eb, ea;
        @(negedge clk);
        sample_l = l; sample_r = r; ch_sel = sel; adclrck = 1'b1;
        repeat (3) @(negedge clk);
        frame_ack = ack_same;
        @(posedge clk); #1;
        frame_ack = 1'b0;
        pre = m_mode;
        if (ack_same && pre != 2) model_ack();
        w = 0; eb = 0; ea = 0;
        if (m_mode == 1) begin
            w = 1; eb = m_fb; ea = m_addr;
            if (m_addr == DEPTH - 1) begin
                q.push_back(m_fb);
                m_addr = 0;
                if (q.size() == 2) m_mode = 2;
                else m_fb ^= 1;
            end else m_addr++;
        end else if (m_mode == 2) begin
            if (m_cnt < 255) m_cnt++;
        end
        if (ack_same && pre == 2) model_ack();
        chk("wr_en", wr_en, w);
        if (w) begin
            chk("wr_bank", wr_bank, eb);
            chk("wr_addr", wr_addr, ea);
            chk("wr_data", wr_data, exp_sample(l, r, sel));
        end
        check_status("evt");
        @(negedge clk);
        adclrck = 1'b0;
        @(negedge clk);
        chk("wr_en_pulse", wr_en, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic send_ack();
        @(negedge clk);
        frame_ack = 1'b1;
        @(posedge clk); #1;
        frame_ack = 1'b0;
        model_ack();
        check_status("ack");
    endtask

    task automatic do_abort();
        @(negedge clk);
        run = 1'b0;
        @(posedge clk); #1;
        m_mode = 0; m_addr = 0;
        check_status("abort");
        @(negedge clk);
        run = 1'b1;
        @(posedge clk); #1;
        model_run_start();
        check_status("restart");
    endtask

    task automatic check_zero(input string where);
        chk({where, ".wr_en"}, wr_en, 0);
        chk({where, ".wr_bank"}, wr_bank, 0);
        chk({where, ".wr_addr"}, wr_addr, 0);
        chk({where, ".wr_data"}, wr_data, 0);
        chk({where, ".valid"}, frame_valid, 0);
        chk({where, ".bank"}, frame_bank, 0);
        chk({where, ".busy"}, busy, 0);
        chk({where, ".ovr"}, overrun_cnt, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_zero("midreset");
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        m_cnt = 0; m_fb = 0; m_addr = 0; m_mode = 0;
        @(posedge clk); #1;
        model_run_start();
        check_status("post_reset");
    endtask

    initial begin
        bit found;
        int c0;
        reset = 1'b1; run = 1'b0; adclrck = 1'b0; ch_sel = 1'b0; frame_ack = 1'b0;
        sample_l = '0; sample_r = '0;
        q.delete();
        m_mode = 0; m_fb = 0; m_addr = 0; m_cnt = 0;

        // Reset with the LR clock toggling, then idle with run low.
        @(negedge clk); adclrck = 1'b1;
        @(negedge clk); adclrck = 1'b0;
        @(posedge clk); #1;
        check_zero("reset");
        @(negedge clk); reset = 1'b0;
        repeat (3) @(negedge clk);
        send_event(16'h1234, 16'h5678, 1'b0, 1'b0);
        check_zero("idle");

        @(negedge clk); run = 1'b1;
        @(posedge clk); #1;
        model_run_start();
        check_status("start");

        // Two frames with an ack of bank 0 partway through the second.
        for (int i = 0; i < 2 * DEPTH; i++) begin
            send_event(DATA_W'(16'h0100 * i), DATA_W'($urandom), 1'b0, 1'b0);
            if (i == DEPTH + 3) send_ack();
        end
        // Overrun: no acks.
        for (int i = 0; i < 20; i++)
            send_event(DATA_W'($urandom), DATA_W'($urandom), 1'(i & 1), 1'b0);
        send_ack();
        send_event(16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
        send_event(16'h8000, 16'hFFFF, 1'b1, 1'b0);
        send_event(16'h8000, 16'h8000, 1'b0, 1'b0);
        send_ack();
        for (int i = 0; i < 5; i++)
            send_event(DATA_W'($urandom), DATA_W'($urandom), 1'b1, 1'b0);
        do_abort();
        send_event(16'hA5A5, 16'h5A5A, 1'b0, 1'b0);

        // Ack coinciding with the completing write of the other bank.
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_mode == 1 && m_addr == DEPTH - 1 && q.size() == 1) found = 1;
            else if (m_mode == 2) send_ack();
            else send_event(DATA_W'($urandom), DATA_W'($urandom), 1'b0, 1'b0);
        end
        chk("simul_setup", found, 1);
        c0 = m_cnt;
        send_event(16'h4321, 16'h1111, 1'b0, 1'b1);
        chk("simul_no_ovr", overrun_cnt, c0);
        chk("simul_busy", busy, 1);

        // Randomized traffic.
        for (int i = 0; i < 250; i++) begin
            int r;
            send_event(DATA_W'($urandom), DATA_W'($urandom), 1'($urandom),
                       ($urandom_range(0, 9) == 0));
            r = $urandom_range(0, 99);
            if (r < 15) send_ack();
            else if (r < 18) do_abort();
            else if (r == 99) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
